// File: rtl/cml_rx_video_axis.sv
// cml_rx_video_axis: CameraLink Base-mode FVAL/LVAL/DVAL pixel stream to AXI4-Stream video.
// Line/frame geometry is checked against COL/ROW; a first-word-fall-through FIFO absorbs backpressure.
module cml_rx_video_axis #(
    parameter int unsigned COL        = 1280,
    parameter int unsigned ROW        = 1024,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          USE_DVAL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fval,
    input  logic        lval,
    input  logic        dval,
    input  logic [7:0]  port_a,
    input  logic [7:0]  port_b,
    input  logic [7:0]  port_c,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic [15:0] frame_cnt,
    output logic        err_line_len,
    output logic        err_line_cnt,
    output logic        err_overflow,
    input  logic        clr_err
);

    localparam int unsigned DW = 24;
    localparam int unsigned EW = DW + 2;
    localparam int unsigned PW = $clog2(COL + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned LW = 16;

    localparam logic [PW-1:0] COL_P    = PW'(COL);
    localparam logic [PW-1:0] COL_M1   = PW'(COL - 1);
    localparam logic [LW-1:0] ROW_P    = LW'(ROW);
    localparam logic [LW-1:0] LINE_MAX = '1;
    localparam logic [CW-1:0] DEPTH_P  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        IDLE  = 2'd1,
        FRAME = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          fval_r_q, fval_r_d;
    logic          lval_r_q, lval_r_d;
    logic          dval_r_q, dval_r_d;
    logic [DW-1:0] data_r_q, data_r_d;
    logic          fval_dly_q, fval_dly_d;
    logic          lval_dly_q, lval_dly_d;
    logic          s0_vld_q, s0_vld_d;

    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [LW-1:0] frame_cnt_q, frame_cnt_d;
    logic          sof_pend_q, sof_pend_d;
    logic          err_len_q, err_len_d;
    logic          err_cnt_q, err_cnt_d;
    logic          err_ovf_q, err_ovf_d;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tvalid_q, tvalid_d;

    logic          fval_rise;
    logic          fval_fall;
    logic          lval_fall;
    logic          pix_ok;
    logic          in_frame;
    logic          wr_req;
    logic          fifo_full;
    logic          fifo_wr;
    logic          fifo_rd;
    logic [EW-1:0] wr_word;
    logic [LW-1:0] line_eff;

    // Stage 0: register the camera inputs once, plus delayed copies for edge detection
    always_comb begin
        fval_r_d   = fval;
        lval_r_d   = lval;
        dval_r_d   = dval;
        data_r_d   = {port_c, port_b, port_a};
        fval_dly_d = fval_r_q;
        lval_dly_d = lval_r_q;
        s0_vld_d   = 1'b1;
    end

    always_comb begin
        fval_rise = fval_r_q & ~fval_dly_q;
        fval_fall = ~fval_r_q & fval_dly_q;
        lval_fall = ~lval_r_q & lval_dly_q;
        pix_ok    = fval_r_q & lval_r_q & (dval_r_q | ~USE_DVAL);
        in_frame  = (state_q == FRAME);
        wr_req    = in_frame & pix_ok & (pix_cnt_q < COL_P);
        fifo_full = (cnt_q == DEPTH_P);
        fifo_wr   = wr_req & ~fifo_full;
        fifo_rd   = tvalid_q & m_axis_tready;
        wr_word   = {sof_pend_q, (pix_cnt_q == COL_M1), data_r_q};
    end

    // s0_vld_q keeps SYNC from trusting the reset value of fval_r before a real sample lands
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SYNC:    if (s0_vld_q && !fval_r_q) state_d = IDLE;
            IDLE:    if (fval_rise) state_d = FRAME;
            FRAME:   if (fval_fall) state_d = IDLE;
            default: state_d = SYNC;
        endcase
    end

    // Geometry counters, start-of-frame tracking and sticky error flags
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        frame_cnt_d = frame_cnt_q;
        sof_pend_d  = sof_pend_q;
        err_len_d   = err_len_q & ~clr_err;
        err_cnt_d   = err_cnt_q & ~clr_err;
        err_ovf_d   = (err_ovf_q & ~clr_err) | (wr_req & fifo_full);

        line_eff = line_cnt_q;
        if (in_frame && lval_fall && line_cnt_q != LINE_MAX) begin
            line_eff = line_cnt_q + LW'(1);
        end

        if (!in_frame) begin
            pix_cnt_d = '0;
        end else if (lval_fall) begin
            pix_cnt_d = '0;
            if (pix_cnt_q != COL_P) err_len_d = 1'b1;
        end else if (pix_ok) begin
            if (pix_cnt_q != COL_P) begin
                pix_cnt_d = pix_cnt_q + PW'(1);
            end else begin
                err_len_d = 1'b1;
            end
        end

        if (in_frame) begin
            line_cnt_d = line_eff;
        end
        if (in_frame && fval_fall) begin
            line_cnt_d  = '0;
            frame_cnt_d = frame_cnt_q + LW'(1);
            if (line_eff != ROW_P) err_cnt_d = 1'b1;
        end

        if (state_q == IDLE && fval_rise) begin
            sof_pend_d = 1'b1;
        end else if (fifo_wr) begin
            sof_pend_d = 1'b0;
        end
    end

    // FIFO bookkeeping; a write while full is dropped even when a read frees a slot
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q] = wr_word;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (fifo_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d    = cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
        tvalid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fval_r_q    <= 1'b0;
            lval_r_q    <= 1'b0;
            dval_r_q    <= 1'b0;
            data_r_q    <= '0;
            fval_dly_q  <= 1'b0;
            lval_dly_q  <= 1'b0;
            s0_vld_q    <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            frame_cnt_q <= '0;
            sof_pend_q  <= 1'b0;
            err_len_q   <= 1'b0;
            err_cnt_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            tvalid_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            fval_r_q    <= fval_r_d;
            lval_r_q    <= lval_r_d;
            dval_r_q    <= dval_r_d;
            data_r_q    <= data_r_d;
            fval_dly_q  <= fval_dly_d;
            lval_dly_q  <= lval_dly_d;
            s0_vld_q    <= s0_vld_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            sof_pend_q  <= sof_pend_d;
            err_len_q   <= err_len_d;
            err_cnt_q   <= err_cnt_d;
            err_ovf_q   <= err_ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            tvalid_q    <= tvalid_d;
            mem_q       <= mem_d;
        end
    end

    // Head entry drives the AXIS outputs directly and holds while tready is low
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];
    assign m_axis_tvalid = tvalid_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_line_len  = err_len_q;
    assign err_line_cnt  = err_cnt_q;
    assign err_overflow  = err_ovf_q;

endmodule

// File: tb/tb_cml_rx_video_axis.sv
// tb_cml_rx_video_axis: directed + randomized frames against a frame-level expected-beat model
// feeding a queue-based FIFO reference with the DUT's one-cycle write latency.
module tb_cml_rx_video_axis;

    localparam int COL   = 4;
    localparam int ROW   = 3;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fval = 1'b0, lval = 1'b0, dval = 1'b0;
    logic [7:0]  port_a = '0, port_b = '0, port_c = '0;
    logic        m_axis_tready = 1'b0;
    logic        clr_err = 1'b0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic [15:0] frame_cnt;
    logic        err_line_len, err_line_cnt, err_overflow;

    cml_rx_video_axis #(
        .COL(COL), .ROW(ROW), .FIFO_DEPTH(DEPTH), .USE_DVAL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .fval(fval), .lval(lval), .dval(dval),
        .port_a(port_a), .port_b(port_b), .port_c(port_c),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
        .m_axis_tlast(m_axis_tlast), .frame_cnt(frame_cnt),
        .err_line_len(err_line_len), .err_line_cnt(err_line_cnt),
        .err_overflow(err_overflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver-side expectations
    int          rdy_mode = 1;
    bit          frame_ok = 1'b0;
    bit          sof_m = 1'b0;
    int          pix_idx = 0;
    bit          drv_wr = 1'b0;
    logic [25:0] drv_word = '0;
    bit          exp_len = 1'b0;
    bit          exp_cnt = 1'b0;
    int          exp_frames = 0;
    int          ln [8];

    // Reference FIFO: words scheduled by the driver land one edge after the DUT samples them
    logic [25:0] mq [$];
    bit          m_pend = 1'b0;
    logic [25:0] m_pend_w = '0;
    bit          m_ovf = 1'b0;
    bit          m_full, m_rd, m_drop;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_pend = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_rd   = (mq.size() != 0) && m_axis_tready;
            m_drop = m_pend && m_full;
            if (m_rd) void'(mq.pop_front());
            if (m_pend && !m_full) mq.push_back(m_pend_w);
            m_ovf    = (m_ovf && !clr_err) || m_drop;
            m_pend   = drv_wr;
            m_pend_w = drv_word;
        end
    end

    int beats = 0;
    bit first_user = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("tdata", 32'(m_axis_tdata), 32'(mq[0][23:0]));
                chk("tuser", 32'(m_axis_tuser), 32'(mq[0][25]));
                chk("tlast", 32'(m_axis_tlast), 32'(mq[0][24]));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (beats == 0) first_user = m_axis_tuser;
                beats++;
            end
        end
    end

    task automatic drive(input bit fv, input bit lv, input bit dv, input bit clr);
        logic [23:0] px;
        @(posedge clk);
        #1;
        px = 24'($urandom);
        fval = fv; lval = lv; dval = dv; clr_err = clr;
        {port_c, port_b, port_a} = px;
        m_axis_tready = (rdy_mode == 2) ? ($urandom_range(3) != 0) : (rdy_mode == 1);
        drv_wr = 1'b0;
        if (frame_ok && fv && lv && dv) begin
            if (pix_idx < COL) begin
                drv_wr   = 1'b1;
                drv_word = {sof_m, (pix_idx == COL - 1), px};
                sof_m    = 1'b0;
            end
            pix_idx++;
        end
    endtask

    // dmode: 0 = dval always 1, 1 = alternating starting with 1, 2 = random
    task automatic send_frame(input int nl, input int dmode, input bit together, input bit clr_end);
        bit len_bad = 1'b0;
        bit dv;
        frame_ok = 1'b1;
        sof_m    = 1'b1;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int l = 0; l < nl; l++) begin
            pix_idx = 0;
            for (int p = 0; p < ln[l]; p++) begin
                dv = (dmode == 0) ? 1'b1 : (dmode == 1) ? (p % 2 == 0) : ($urandom_range(3) != 0);
                drive(1, 1, dv, 0);
            end
            if (pix_idx != COL) len_bad = 1'b1;
            if (!(together && l == nl - 1)) begin
                drive(1, 0, 0, 0);
                drive(1, 0, 0, 0);
            end
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, clr_end);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        frame_ok = 1'b0;
        if (len_bad) exp_len = 1'b1;
        if (nl != ROW) exp_cnt = 1'b1;
        exp_frames++;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames[15:0]));
        chk({tag, "_err_len"}, 32'(err_line_len), 32'(exp_len));
        chk({tag, "_err_cnt"}, 32'(err_line_cnt), 32'(exp_cnt));
        chk({tag, "_err_ovf"}, 32'(err_overflow), 32'(m_ovf));
    endtask

    task automatic clear_errs(input string tag);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        exp_len = 1'b0;
        exp_cnt = 1'b0;
        check_flags(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && mq.size() != 0; i++) drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk({tag, "_drained"}, 32'(m_axis_tvalid), 32'(0));
    endtask

    task automatic set_lines(input int a, input int b, input int c, input int d);
        ln[0] = a; ln[1] = b; ln[2] = c; ln[3] = d;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        chk("rst_tdata", 32'(m_axis_tdata), 32'(0));
        chk("rst_tuser", 32'(m_axis_tuser), 32'(0));
        chk("rst_tlast", 32'(m_axis_tlast), 32'(0));
        chk("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        chk("rst_err_len", 32'(err_line_len), 32'(0));
        chk("rst_err_cnt", 32'(err_line_cnt), 32'(0));
        chk("rst_err_ovf", 32'(err_overflow), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) drive(0, 0, 0, 0);

        // Clean frame
        rdy_mode = 1;
        beats = 0;
        set_lines(COL, COL, COL, 0);
        send_frame(ROW, 0, 0, 0);
        drain("t1");
        chk("t1_beats", 32'(beats), 32'(COL * ROW));
        chk("t1_first_tuser", 32'(first_user), 32'(1));
        check_flags("t1");

        // Overlong first line
        beats = 0;
        set_lines(COL + 1, COL, COL, 0);
        send_frame(ROW, 0, 0, 0);
        drain("t3");
        chk("t3_beats", 32'(beats), 32'(COL * ROW));
        chk("t3_err_len_set", 32'(err_line_len), 32'(1));
        check_flags("t3");
        clear_errs("t3_clr");

        // dval alternating over a 2*COL lval window
        beats = 0;
        set_lines(2 * COL, 2 * COL, 2 * COL, 0);
        send_frame(ROW, 1, 0, 0);
        drain("t6");
        chk("t6_beats", 32'(beats), 32'(COL * ROW));
        check_flags("t6");

        // Backpressure for the whole frame, then release
        rdy_mode = 0;
        set_lines(COL, COL, COL, 0);
        send_frame(ROW, 0, 0, 0);
        chk("t4_err_ovf_set", 32'(err_overflow), 32'(1));
        chk("t4_tvalid_held", 32'(m_axis_tvalid), 32'(1));
        check_flags("t4");
        beats = 0;
        rdy_mode = 1;
        drain("t4");
        chk("t4_beats", 32'(beats), 32'(DEPTH));
        clear_errs("t4_clr");

        // Short frame, clear on a quiet cycle, clear coincident with a new error
        set_lines(COL, COL, 0, 0);
        send_frame(ROW - 1, 0, 0, 0);
        drain("t5a");
        chk("t5_err_cnt_set", 32'(err_line_cnt), 32'(1));
        check_flags("t5a");
        clear_errs("t5_clr_quiet");
        send_frame(ROW - 1, 0, 0, 1);
        drain("t5b");
        chk("t5_err_cnt_held", 32'(err_line_cnt), 32'(1));
        check_flags("t5b");
        clear_errs("t5_clr2");

        // Last lval falls together with fval: that line still counts
        set_lines(COL, COL, COL, 0);
        send_frame(ROW, 0, 1, 0);
        drain("tog");
        check_flags("tog");

        // Reset released mid-frame with data queued in the FIFO
        rdy_mode = 0;
        frame_ok = 1'b1;
        sof_m = 1'b1;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        pix_idx = 0;
        repeat (COL) drive(1, 1, 1, 0);
        drive(1, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        frame_ok = 1'b0;
        drv_wr = 1'b0;
        exp_frames = 0;
        exp_len = 1'b0;
        exp_cnt = 1'b0;
        repeat (2) drive(1, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 1;
        beats = 0;
        for (int l = 0; l < 2; l++) begin
            repeat (COL) drive(1, 1, 1, 0);
            drive(1, 0, 0, 0);
            drive(1, 0, 0, 0);
        end
        repeat (4) drive(0, 0, 0, 0);
        chk("t2_beats_mid", 32'(beats), 32'(0));
        check_flags("t2_mid");
        set_lines(COL, COL, COL, 0);
        send_frame(ROW, 0, 0, 0);
        drain("t2");
        chk("t2_beats", 32'(beats), 32'(COL * ROW));
        chk("t2_first_tuser", 32'(first_user), 32'(1));
        check_flags("t2");

        // Randomized frames under random backpressure
        rdy_mode = 2;
        for (int f = 0; f < 24; f++) begin
            int nl;
            nl = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? ROW - 1 : ROW + 1) : ROW;
            for (int l = 0; l < nl; l++) begin
                case ($urandom_range(4))
                    0, 1:    ln[l] = COL;
                    2:       ln[l] = COL - 1;
                    3:       ln[l] = COL + 1;
                    default: ln[l] = COL + 2;
                endcase
            end
            send_frame(nl, 2 * int'($urandom_range(1)), bit'($urandom_range(1)), 0);
            drain("rnd");
            check_flags("rnd");
            clear_errs("rnd_clr");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
